rr_slave_port_mux: RTL and testbench

- Parametrised N-master to 1-slave port for the crossbar.
- Successor to the fixed two-master slave-side mux: it embeds its own round-robin arbiter instead of taking an external grant.
- Locks the grant for a whole req/ack transaction, registers all outputs, and adds an optional ack timeout with error return.
- Sits in front of each slave; one instance per slave in the crossbar.

---
 rtl/xbar_pkg.sv | 40 ++++
 rtl/rr_arbiter.sv | 33 +++
 rtl/rr_slave_port_mux.sv | 153 +++++++++++++++
 tb/tb_rr_slave_port_mux.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared crossbar types, command encodings and round-robin pick helper
package xbar_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } xbar_state_e;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   localparam int RR_MAX   = 32;
   localparam int RR_IDX_W = $clog2(RR_MAX);

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First requester strictly after ptr with wrap-around; only the low 'masters' bits of req count.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   req,
                                        input logic [RR_IDX_W-1:0] ptr,
                                        input int                  masters);
      rr_pick_t r;
      int       i;
      r = '0;
      for (int off = RR_MAX; off >= 1; off--) begin
         if (off <= masters) begin
            i = (int'(ptr) + off) % masters;
            if (req[RR_IDX_W'(i)]) begin
               r.found = 1'b1;
               r.idx   = RR_IDX_W'(i);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick with a registered priority pointer
// The pointer only moves when the owner of a finished transaction is written back.
module rr_arbiter
   import xbar_pkg::*;
#(
   parameter  int MASTERS = 4,
   localparam int IDX_W   = $clog2(MASTERS)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [MASTERS-1:0] req_i,
   input  logic               upd_en_i,
   input  logic [IDX_W-1:0]   upd_idx_i,
   output logic               found_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   rr_pick_t         pick;

   always_comb begin
      pick    = rr_pick(RR_MAX'(req_i), RR_IDX_W'(ptr_q), MASTERS);
      found_o = pick.found;
      idx_o   = IDX_W'(pick.idx);
      ptr_d   = upd_en_i ? upd_idx_i : ptr_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= IDX_W'(MASTERS - 1);
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/rr_slave_port_mux.sv
// rtl/rr_slave_port_mux.sv - N-master to 1-slave port with locked round-robin grant and ack timeout
// All outputs are registered; a transaction runs IDLE -> BUSY -> RESP.
module rr_slave_port_mux
   import xbar_pkg::*;
#(
   parameter  int MASTERS = 4,
   parameter  int N       = 32,
   parameter  int TIMEOUT = 0,
   localparam int IDX_W   = $clog2(MASTERS),
   localparam int TO_W    = $clog2(TIMEOUT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [MASTERS-1:0]   master_req,
   input  logic [MASTERS-1:0]   master_cmd,
   input  logic [MASTERS*N-1:0] master_addr,
   input  logic [MASTERS*N-1:0] master_wdata,
   output logic [MASTERS-1:0]   master_ack,
   output logic [MASTERS*N-1:0] master_rdata,
   output logic [MASTERS-1:0]   master_err,
   output logic                 slave_req,
   output logic [N-1:0]         slave_addr,
   output logic                 slave_cmd,
   output logic [N-1:0]         slave_wdata,
   input  logic                 slave_ack,
   input  logic [N-1:0]         slave_rdata,
   output logic [MASTERS-1:0]   grant
);

   localparam int CNT_W = (TO_W < 1) ? 1 : TO_W;

   xbar_state_e          state_q, state_d;
   logic [IDX_W-1:0]     gidx_q, gidx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 slave_req_q, slave_req_d;
   logic                 slave_cmd_q, slave_cmd_d;
   logic [N-1:0]         slave_addr_q, slave_addr_d;
   logic [N-1:0]         slave_wdata_q, slave_wdata_d;
   logic [MASTERS-1:0]   grant_q, grant_d;
   logic [MASTERS-1:0]   ack_q, ack_d;
   logic [MASTERS-1:0]   err_q, err_d;
   logic [MASTERS*N-1:0] rdata_q, rdata_d;

   logic                 arb_found;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_upd;
   logic                 timeout_hit;

   rr_arbiter #(.MASTERS(MASTERS)) u_arb (
      .clk_i     (clk),
      .rst_ni    (rst),
      .req_i     (master_req),
      .upd_en_i  (arb_upd),
      .upd_idx_i (gidx_q),
      .found_o   (arb_found),
      .idx_o     (arb_idx)
   );

   // cnt_q counts completed BUSY cycles, so TIMEOUT-1 marks the last one.
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         gidx_q        <= '0;
         cnt_q         <= '0;
         slave_req_q   <= 1'b0;
         slave_cmd_q   <= 1'b0;
         slave_addr_q  <= '0;
         slave_wdata_q <= '0;
         grant_q       <= '0;
         ack_q         <= '0;
         err_q         <= '0;
         rdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         gidx_q        <= gidx_d;
         cnt_q         <= cnt_d;
         slave_req_q   <= slave_req_d;
         slave_cmd_q   <= slave_cmd_d;
         slave_addr_q  <= slave_addr_d;
         slave_wdata_q <= slave_wdata_d;
         grant_q       <= grant_d;
         ack_q         <= ack_d;
         err_q         <= err_d;
         rdata_q       <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arb_found) state_d = BUSY;
         BUSY:    if (slave_ack || timeout_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gidx_d        = gidx_q;
      cnt_d         = cnt_q;
      slave_req_d   = slave_req_q;
      slave_cmd_d   = slave_cmd_q;
      slave_addr_d  = slave_addr_q;
      slave_wdata_d = slave_wdata_q;
      grant_d       = grant_q;
      ack_d         = '0;
      err_d         = '0;
      rdata_d       = '0;
      arb_upd       = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_found) begin
               gidx_d        = arb_idx;
               cnt_d         = '0;
               slave_req_d   = 1'b1;
               slave_cmd_d   = master_cmd[arb_idx] ? CMD_WRITE : CMD_READ;
               slave_addr_d  = master_addr[int'(arb_idx)*N +: N];
               slave_wdata_d = master_wdata[int'(arb_idx)*N +: N];
               grant_d       = MASTERS'(1) << arb_idx;
            end
         end
         BUSY: begin
            if (slave_ack || timeout_hit) begin
               ack_d[gidx_q] = 1'b1;
               err_d[gidx_q] = !slave_ack;
               if (slave_ack) rdata_d[int'(gidx_q)*N +: N] = slave_rdata;
               slave_req_d   = 1'b0;
               slave_cmd_d   = CMD_READ;
               slave_addr_d  = '0;
               slave_wdata_d = '0;
               cnt_d         = '0;
               arb_upd       = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP:    grant_d = '0;
         default: ;
      endcase
   end

   assign master_ack   = ack_q;
   assign master_err   = err_q;
   assign master_rdata = rdata_q;
   assign slave_req    = slave_req_q;
   assign slave_cmd    = slave_cmd_q;
   assign slave_addr   = slave_addr_q;
   assign slave_wdata  = slave_wdata_q;
   assign grant        = grant_q;

endmodule

// File: tb/tb_rr_slave_port_mux.sv
// tb/tb_rr_slave_port_mux.sv - scoreboard bench for rr_slave_port_mux (4 masters, 32-bit, timeout 8)
module tb_rr_slave_port_mux;
   import xbar_pkg::*;

   localparam int M  = 4;
   localparam int N  = 32;
   localparam int TO = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [M-1:0]   master_req, master_cmd, master_ack, master_err, grant;
   logic [M*N-1:0] master_addr, master_wdata, master_rdata;
   logic           slave_req, slave_cmd, slave_ack;
   logic [N-1:0]   slave_addr, slave_wdata, slave_rdata;

   always #5 clk = ~clk;

   rr_slave_port_mux #(.MASTERS(M), .N(N), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .master_req   (master_req),
      .master_cmd   (master_cmd),
      .master_addr  (master_addr),
      .master_wdata (master_wdata),
      .master_ack   (master_ack),
      .master_rdata (master_rdata),
      .master_err   (master_err),
      .slave_req    (slave_req),
      .slave_addr   (slave_addr),
      .slave_cmd    (slave_cmd),
      .slave_wdata  (slave_wdata),
      .slave_ack    (slave_ack),
      .slave_rdata  (slave_rdata),
      .grant        (grant)
   );

   typedef struct {
      logic [M-1:0] grant;
      logic [N-1:0] addr;
      logic         cmd;
      logic [N-1:0] wdata;
   } req_t;

   typedef struct {
      logic [M-1:0]   ack;
      logic [M-1:0]   err;
      logic [M*N-1:0] rdata;
      int             busy;
   } rsp_t;

   req_t         exp_req[$];
   rsp_t         exp_rsp[$];
   int           checks   = 0;
   int           failures = 0;
   int           pend[M];
   logic [M-1:0] drop_mask;
   logic [N-1:0] m_addr[M];
   logic [N-1:0] m_wdata[M];
   logic         m_cmd[M];
   int           ack_delay;
   bit           inject_ack;
   int           busy_n, cur_busy;
   logic         prev_req;
   req_t         cur;

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] rd_fn(input logic [N-1:0] a);
      return {16'hA5A5, a[15:0]};
   endfunction

   function automatic int pend_sum();
      int s = 0;
      for (int i = 0; i < M; i++) s += pend[i];
      return s;
   endfunction

   task automatic queue_txn(input int m, input bit timed_out, input bit with_rsp);
      req_t q;
      rsp_t r;
      q.grant = M'(1) << m;
      q.addr  = m_addr[m];
      q.cmd   = m_cmd[m];
      q.wdata = m_wdata[m];
      r.ack   = q.grant;
      r.err   = timed_out ? q.grant : '0;
      r.rdata = '0;
      if (!timed_out) r.rdata[m*N +: N] = rd_fn(m_addr[m]);
      r.busy  = timed_out ? TO : ack_delay + 1;
      exp_req.push_back(q);
      if (with_rsp) exp_rsp.push_back(r);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while ((exp_rsp.size() != 0 || pend_sum() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, exp_rsp.size() + pend_sum(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_issue(input string tag, input int budget);
      int n = 0;
      while (!slave_req && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, slave_req, 1);
   endtask

   // Masters, slave responder and scoreboard monitor share one negedge loop for a fixed order.
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         if (inject_ack) begin
            slave_ack   = 1'b1;
            slave_rdata = $urandom;
            inject_ack  = 1'b0;
         end else if (slave_req && busy_n == ack_delay) begin
            slave_ack   = 1'b1;
            slave_rdata = rd_fn(slave_addr);
         end else begin
            slave_ack   = 1'b0;
            slave_rdata = $urandom;
         end
         busy_n = slave_req ? busy_n + 1 : 0;

         if (!rst) begin
            cur_busy = 0;
            prev_req = 1'b0;
         end else begin
            if (slave_req && !prev_req) begin
               if (exp_req.size() == 0) chk("unexpected_issue", slave_req, 0);
               else begin
                  cur = exp_req.pop_front();
                  chk("issue_grant", grant, cur.grant);
                  chk("issue_fields", {slave_addr, slave_cmd, slave_wdata}, {cur.addr, cur.cmd, cur.wdata});
               end
            end else if (slave_req) begin
               chk("busy_hold", {grant, slave_addr, slave_cmd, slave_wdata},
                   {cur.grant, cur.addr, cur.cmd, cur.wdata});
            end
            if (slave_req) cur_busy++;
            if (master_ack != '0) begin
               if (exp_rsp.size() == 0) chk("unexpected_ack", master_ack, 0);
               else begin
                  r = exp_rsp.pop_front();
                  chk("rsp_ack", master_ack, r.ack);
                  chk("rsp_err", master_err, r.err);
                  chk("rsp_rdata", master_rdata, r.rdata);
                  chk("rsp_busy_cycles", cur_busy, r.busy);
                  chk("rsp_grant_held", grant, r.ack);
                  chk("rsp_slave_clear", {slave_req, slave_addr, slave_cmd, slave_wdata}, 0);
               end
               cur_busy = 0;
            end else begin
               chk("quiet", {master_err, master_rdata, (slave_req ? 4'b0 : grant)}, 0);
            end
            prev_req = slave_req;
         end

         for (int i = 0; i < M; i++) begin
            if (master_ack[i] && pend[i] > 0) pend[i]--;
            master_req[i]           = (pend[i] > 0) && !drop_mask[i];
            master_cmd[i]           = m_cmd[i];
            master_addr[i*N +: N]   = m_addr[i];
            master_wdata[i*N +: N]  = m_wdata[i];
         end
      end
   end

   initial begin
      master_req   = '0;
      master_cmd   = '0;
      master_addr  = '0;
      master_wdata = '0;
      slave_ack    = 1'b0;
      slave_rdata  = '0;
      drop_mask    = '0;
      ack_delay    = -1;
      inject_ack   = 1'b0;
      busy_n       = 0;
      cur_busy     = 0;
      prev_req     = 1'b0;
      for (int i = 0; i < M; i++) begin
         pend[i]    = 0;
         m_addr[i]  = 32'h100 + 32'(i * 4);
         m_wdata[i] = 32'h1111_0000 + 32'(i);
         m_cmd[i]   = CMD_READ;
      end

      repeat (2) @(negedge clk);
      chk("reset_outputs", {slave_req, slave_cmd, slave_addr, slave_wdata, grant, master_ack, master_err}, 0);
      chk("reset_rdata", master_rdata, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_no_req", {slave_req, grant}, 0);

      // single write from master 2
      m_cmd[2] = CMD_WRITE; m_addr[2] = 32'h10; m_wdata[2] = 32'hDEADBEEF;
      ack_delay = 2;
      queue_txn(2, 1'b0, 1'b1);
      pend[2] = 1;
      wait_drain("drain_write", 40);

      // read from master 0
      m_cmd[0] = CMD_READ; m_addr[0] = 32'h0000_0001;
      ack_delay = 1;
      queue_txn(0, 1'b0, 1'b1);
      pend[0] = 1;
      wait_drain("drain_read", 40);

      // reset in the middle of a BUSY transaction
      m_addr[1] = 32'h44;
      ack_delay = -1;
      queue_txn(1, 1'b1, 1'b0);
      pend[1] = 1;
      wait_issue("issue_before_reset", 20);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midbusy_reset_outputs", {slave_req, slave_cmd, slave_addr, slave_wdata, grant, master_ack, master_err}, 0);
      chk("midbusy_reset_rdata", master_rdata, 0);
      for (int i = 0; i < M; i++) pend[i] = 0;
      exp_req.delete();
      exp_rsp.delete();
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_reset_idle", {slave_req, grant, master_ack}, 0);

      // round robin with all four held and immediate acks
      for (int i = 0; i < M; i++) begin
         m_addr[i]  = 32'h100 + 32'(i * 4);
         m_wdata[i] = 32'h2222_0000 + 32'(i);
         m_cmd[i]   = (i % 2 == 1) ? CMD_WRITE : CMD_READ;
      end
      ack_delay = 0;
      queue_txn(0, 1'b0, 1'b1);
      queue_txn(1, 1'b0, 1'b1);
      queue_txn(2, 1'b0, 1'b1);
      queue_txn(3, 1'b0, 1'b1);
      queue_txn(0, 1'b0, 1'b1);
      pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
      wait_drain("drain_rr", 80);

      // grant lock: master 1 drops and changes inputs, master 3 arrives
      m_addr[1] = 32'h200; m_cmd[1] = CMD_WRITE; m_wdata[1] = 32'hCAFE_0001;
      ack_delay = 3;
      queue_txn(1, 1'b0, 1'b1);
      pend[1] = 1;
      wait_issue("issue_lock", 20);
      m_addr[3] = 32'h300; m_cmd[3] = CMD_READ;
      queue_txn(3, 1'b0, 1'b1);
      pend[3] = 1;
      drop_mask[1] = 1'b1;
      m_addr[1] = 32'hBAD0; m_wdata[1] = 32'h0BAD_0BAD;
      wait_drain("drain_lock", 60);
      drop_mask = '0;

      // timeout with no slave ack, then a late ack while idle
      m_addr[2] = 32'h20; m_cmd[2] = CMD_READ;
      ack_delay = -1;
      queue_txn(2, 1'b1, 1'b1);
      pend[2] = 1;
      wait_drain("drain_timeout", 60);
      inject_ack = 1'b1;
      repeat (3) @(negedge clk);
      chk("late_ack_ignored", {master_ack, master_err, slave_req, grant}, 0);

      // ack on the last BUSY cycle wins over the timeout
      m_addr[3] = 32'h3C; m_cmd[3] = CMD_WRITE; m_wdata[3] = 32'h5555_AAAA;
      ack_delay = TO - 1;
      queue_txn(3, 1'b0, 1'b1);
      pend[3] = 1;
      wait_drain("drain_ack_at_limit", 60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
